arbiter_two_rr: RTL and testbench
=================================

# arbiter_two_rr

Two-input, one-output round-robin arbiter on valid/ready streams with a zero-latency combinational datapath. It merges two producers (in_0, in_1) onto one consumer (out) wherever stream paths converge in the design. A registered pointer alternates grants under contention. The grant is held while a presented beat is stalled.

## Interface
- DWIDTH, default 32: data width of all streams.
- PRIORITY_0, default 1: 1 means in_0 wins the first contention after reset; 0 means in_1 wins it.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_0_valid  in  1  port 0 beat valid.
- in_0_data  in  DWIDTH  port 0 payload.
- in_0_ready  out  1  port 0 beat accepted this cycle.
- in_1_valid  in  1  port 1 beat valid.
- in_1_data  in  DWIDTH  port 1 payload.
- in_1_ready  out  1  port 1 beat accepted this cycle.
- out_valid  out  1  output beat valid.
- out_data  out  DWIDTH  output payload.
- out_ready  in  1  downstream accepts.

## Operation
- State: pref (1 bit, preferred input), lock (1 bit), lock_sel (1 bit).
- Grant selection, combinational:
  - if lock=1: grant = lock_sel;
  - else if only one input is valid: grant that input;
  - else if both are valid: grant = pref;
  - else: no grant.
- out_valid = in_0_valid | in_1_valid, forced 0 while rst=0.
- out_data = data of the granted input; in_0_data when there is no grant.
- in_x_ready = out_ready & out_valid & (grant == x). The non-granted ready is always 0.
- Transfer = out_valid & out_ready.
  - On transfer: pref <= ~grant, lock <= 0.
  - On out_valid & ~out_ready: lock <= 1, lock_sel <= grant.
- Round-robin fairness: under continuous contention with out_ready=1, grants alternate 0,1,0,1…. A single active input gets every cycle.
- Producers must hold valid/data until ready (AXI-stream rule). The arbiter's own out_data is stable while stalled because of the lock.

## Timing
- Zero latency from in_x_valid/data to out_valid/out_data, and from out_ready to in_x_ready.
- State updates on the rising edge of clk only.
- Reset (rst=0, asynchronous):
  - pref <= PRIORITY_0 ? 0 : 1;
  - lock <= 0; lock_sel <= 0;
  - out_valid, in_0_ready and in_1_ready are 0 throughout reset.
- Reset mid-stall clears the lock. After release, arbitration restarts from the PRIORITY_0 preference.
- A stalled locked grant is never switched, even if the other input becomes valid.
- Simultaneous valid on the cycle after an in_1 transfer: in_0 wins, and vice versa.
- Both inputs idle: pref is unchanged.

## Structure
- No shared package is required. Grant/pref are 1-bit values; optionally define a 1-bit port_sel_t in the project's common stream package if one exists.
- Single module with no sub-modules: one always_ff for pref/lock/lock_sel and one always_comb for grant/mux/ready.

## Test plan
All scenarios use DWIDTH=16 and PRIORITY_0=1, with in_0_data=0xDEAD and in_1_data=0xBEEF.
- Reset: hold rst=0 with all valids 0, then release. Required: out_valid=0, both readies 0.
- Single requester: in_1_valid=1, in_0_valid=0, out_ready=1. Required, same cycle: out_valid=1, out_data=0xBEEF, in_1_ready=1, in_0_ready=0.
- Alternation: the cycle after the in_1 transfer, both valid with out_ready=1. Required: in_0_ready=1, out_data=0xDEAD. Next cycle: in_1 granted, 0xBEEF.
- Initial priority: fresh reset, both valid at once. Required: in_0 granted (0xDEAD). With PRIORITY_0=0, in_1 is granted (0xBEEF).
- Stall lock: in_1 only valid, out_ready=0 for 3 cycles, then in_0 also raises valid, then out_ready=1. Required: out_data stays 0xBEEF and both readies stay 0 during the stall. The in_1 beat transfers first, then in_0.
- Async reset mid-stall: assert rst=0 between clock edges while locked. Required: outputs drop to 0 immediately; after release, both-valid grants in_0.

Source files
------------

// File: rtl/arbiter_two_rr_pkg.sv
// Shared types for the two-input round-robin stream arbiter.
// Port selects are a single bit: 0 picks in_0, 1 picks in_1.
package arbiter_two_rr_pkg;

   typedef logic port_sel_t;

   localparam port_sel_t PORT_0 = 1'b0;
   localparam port_sel_t PORT_1 = 1'b1;

endpackage

// File: rtl/arbiter_two_rr.sv
// Two-to-one round-robin valid/ready merge, zero-latency datapath.
// A stalled beat locks its grant until it is accepted.
import arbiter_two_rr_pkg::*;

module arbiter_two_rr #(
   parameter int DWIDTH     = 32,
   parameter bit PRIORITY_0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_0_valid,
   input  logic [DWIDTH-1:0] in_0_data,
   output logic              in_0_ready,
   input  logic              in_1_valid,
   input  logic [DWIDTH-1:0] in_1_data,
   output logic              in_1_ready,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_ready
);

   localparam port_sel_t PREF_RST = PRIORITY_0 ? PORT_0 : PORT_1;

   port_sel_t pref;
   logic      lock;
   port_sel_t lock_sel;

   port_sel_t grant;
   logic      grant_vld;
   logic      xfer;
   logic      stall;

   always_comb begin
      grant     = PORT_0;
      grant_vld = 1'b0;
      if (lock) begin
         grant     = lock_sel;
         grant_vld = 1'b1;
      end else if (in_0_valid && in_1_valid) begin
         grant     = pref;
         grant_vld = 1'b1;
      end else if (in_0_valid) begin
         grant     = PORT_0;
         grant_vld = 1'b1;
      end else if (in_1_valid) begin
         grant     = PORT_1;
         grant_vld = 1'b1;
      end
   end

   always_comb begin
      out_valid  = rst & (in_0_valid | in_1_valid);
      out_data   = in_0_data;
      in_0_ready = 1'b0;
      in_1_ready = 1'b0;
      if (grant_vld && grant == PORT_1)
         out_data = in_1_data;
      if (out_valid && out_ready && grant_vld) begin
         in_0_ready = (grant == PORT_0);
         in_1_ready = (grant == PORT_1);
      end
   end

   assign xfer  = out_valid & out_ready;
   assign stall = out_valid & ~out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pref     <= PREF_RST;
         lock     <= 1'b0;
         lock_sel <= PORT_0;
      end else if (xfer) begin
         pref <= ~grant;
         lock <= 1'b0;
      end else if (stall) begin
         lock     <= 1'b1;
         lock_sel <= grant;
      end
   end

endmodule

// File: tb/tb_arbiter_two_rr.sv
// Directed vector bench for arbiter_two_rr (DWIDTH=16).
// A second instance with PRIORITY_0=0 checks the reset preference.
module tb_arbiter_two_rr;

   localparam logic [15:0] D0 = 16'hDEAD;
   localparam logic [15:0] D1 = 16'hBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v0 = 1'b0;
   logic        v1 = 1'b0;
   logic        ordy = 1'b0;
   logic [15:0] d0 = D0;
   logic [15:0] d1 = D1;

   logic        r0, r1, ov;
   logic [15:0] od;
   logic        q_r0, q_r1, q_ov;
   logic [15:0] q_od;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   arbiter_two_rr #(.DWIDTH(16), .PRIORITY_0(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_0_valid(v0), .in_0_data(d0), .in_0_ready(r0),
      .in_1_valid(v1), .in_1_data(d1), .in_1_ready(r1),
      .out_valid(ov), .out_data(od), .out_ready(ordy)
   );

   arbiter_two_rr #(.DWIDTH(16), .PRIORITY_0(1'b0)) dut_p1 (
      .clk(clk), .rst(rst),
      .in_0_valid(v0), .in_0_data(d0), .in_0_ready(q_r0),
      .in_1_valid(v1), .in_1_data(d1), .in_1_ready(q_r1),
      .out_valid(q_ov), .out_data(q_od), .out_ready(ordy)
   );

   typedef struct {
      logic        rst;
      logic        v0;
      logic        v1;
      logic        ordy;
      logic        ov;
      logic [15:0] od;
      logic        r0;
      logic        r1;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic chk(input string name, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      //            rst  v0   v1   rdy  ov   data r0   r1
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,D0,1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,D0,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,D0,1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,D1,1'b0,1'b1};
      vecs[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,D0,1'b1,1'b0};
      vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,D1,1'b0,1'b1};
      vecs[6]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,D0,1'b1,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,D0,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,D1,1'b0,1'b1};
      vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,D0,1'b1,1'b0};
      vecs[10] = '{1'b1,1'b0,1'b1,1'b1,1'b1,D1,1'b0,1'b1};
      vecs[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,D1,1'b0,1'b0};
      vecs[12] = '{1'b1,1'b0,1'b1,1'b0,1'b1,D1,1'b0,1'b0};
      vecs[13] = '{1'b1,1'b0,1'b1,1'b0,1'b1,D1,1'b0,1'b0};
      vecs[14] = '{1'b1,1'b1,1'b1,1'b0,1'b1,D1,1'b0,1'b0};
      vecs[15] = '{1'b1,1'b1,1'b1,1'b1,1'b1,D1,1'b0,1'b1};
      vecs[16] = '{1'b1,1'b1,1'b0,1'b1,1'b1,D0,1'b1,1'b0};
      vecs[17] = '{1'b1,1'b1,1'b0,1'b0,1'b1,D0,1'b0,1'b0};
      vecs[18] = '{1'b1,1'b1,1'b1,1'b0,1'b1,D0,1'b0,1'b0};
      vecs[19] = '{1'b1,1'b1,1'b1,1'b1,1'b1,D0,1'b1,1'b0};
      vecs[20] = '{1'b1,1'b0,1'b1,1'b0,1'b1,D1,1'b0,1'b0};

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst  = vecs[i].rst;
         v0   = vecs[i].v0;
         v1   = vecs[i].v1;
         ordy = vecs[i].ordy;
         #1;
         chk("out_valid",  i, 16'(ov), 16'(vecs[i].ov));
         chk("out_data",   i, od,      vecs[i].od);
         chk("in_0_ready", i, 16'(r0), 16'(vecs[i].r0));
         chk("in_1_ready", i, 16'(r1), 16'(vecs[i].r1));
      end

      // Locked on in_1 with pref=1; reset between edges must drop outputs.
      @(posedge clk);
      #2;
      rst  = 1'b0;
      ordy = 1'b1;
      #1;
      chk("rst_mid_valid", 100, 16'(ov), 16'h0);
      chk("rst_mid_r0",    100, 16'(r0), 16'h0);
      chk("rst_mid_r1",    100, 16'(r1), 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      v0  = 1'b1;
      v1  = 1'b1;
      #1;
      chk("post_rst_data",  101, od,      D0);
      chk("post_rst_r0",    101, 16'(r0), 16'h1);
      chk("post_rst_r1",    101, 16'(r1), 16'h0);
      chk("prio1_data",     101, q_od,    D1);
      chk("prio1_r1",       101, 16'(q_r1), 16'h1);
      chk("prio1_valid",    101, 16'(q_ov), 16'h1);
      @(negedge clk);
      #1;
      chk("post_rst_alt",   102, od,      D1);
      chk("post_rst_alt_r1",102, 16'(r1), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
